// File: rtl/vedic_add_scheduler.sv
// Two-requester round-robin scheduler that time-shares one 16-bit Vedic adder for 32-bit add with carry.
// Accept in IDLE, low half in LOW, high half in HIGH, response held in RESP until rsp_ready.

module sixteen_bit_vedic_adder (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] out,
  output logic        cout
);
  logic [16:0] total;

  assign total = {1'b0, in1} + {1'b0, in2} + {16'b0, cin};
  assign out   = total[15:0];
  assign cout  = total[16];
endmodule

module vedic_add_scheduler #(
  parameter logic PRIO_RST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

  state_t      state, state_next;
  logic        prio;
  logic        carry;
  logic [31:0] op_a, op_b;
  logic        op_cin, op_id;

  logic        grant0, grant1;
  logic [15:0] add_in1, add_in2, add_out;
  logic        add_cin, add_cout;

  sixteen_bit_vedic_adder u_adder (
    .in1  (add_in1),
    .in2  (add_in2),
    .cin  (add_cin),
    .out  (add_out),
    .cout (add_cout)
  );

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    add_in1    = op_a[15:0];
    add_in2    = op_b[15:0];
    add_cin    = op_cin;
    state_next = state;

    // Contention resolves to the priority holder; a lone requester always wins.
    grant0 = req0_valid && (!req1_valid || !prio);
    grant1 = req1_valid && (!req0_valid || prio);

    case (state)
      IDLE: begin
        req0_ready = grant0 && !rst;
        req1_ready = grant1 && !rst;
        if (grant0 || grant1) state_next = LOW;
      end
      LOW:  state_next = HIGH;
      HIGH: begin
        add_in1    = op_a[31:16];
        add_in2    = op_b[31:16];
        add_cin    = carry;
        state_next = RESP;
      end
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= PRIO_RST;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op_a   <= req0_a;
            op_b   <= req0_b;
            op_cin <= req0_cin;
            op_id  <= 1'b0;
          end else if (req1_ready) begin
            op_a   <= req1_a;
            op_b   <= req1_b;
            op_cin <= req1_cin;
            op_id  <= 1'b1;
          end
        end
        LOW: begin
          rsp_sum[15:0] <= add_out;
          carry         <= add_cout;
        end
        HIGH: begin
          rsp_sum[31:16] <= add_out;
          rsp_cout       <= add_cout;
          rsp_id         <= op_id;
          rsp_valid      <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= ~op_id;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_add_scheduler.sv
// Randomized and directed bench for vedic_add_scheduler against a 33-bit arithmetic and round-robin model.
module tb_vedic_add_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [31:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vedic_add_scheduler #(.PRIO_RST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'b0, cin};
  endfunction

  task automatic apply_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one op on one requester, wait for its ready, then drop valid and scramble operands.
  task automatic do_accept(input bit id, input logic [31:0] a, input logic [31:0] b, input logic cin, output bit ok);
    ok = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1));
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rsp(output bit got, output logic [31:0] s, output logic c, output logic rid, output int lat);
    got = 1'b0; lat = 0; s = '0; c = 1'b0; rid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin got = 1'b1; s = rsp_sum; c = rsp_cout; rid = rsp_id; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got v=%b s=%h c=%b id=%b exp all zero", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [3] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] tb [3] = '{32'h00000001, 32'h00000000, 32'h80000000};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    bit          tid[3] = '{1'b0, 1'b1, 1'b1};
    logic [32:0] exp_v [3] = '{33'h0_00010000, 33'h1_00000000, 33'h1_00000000};
    bit ok, got; logic [31:0] s; logic c, rid; int lat;
    for (int k = 0; k < 3; k++) begin
      do_accept(tid[k], ta[k], tb[k], tc[k], ok);
      wait_rsp(got, s, c, rid, lat);
      checks++;
      if (!ok || !got || {c, s} !== exp_v[k] || rid !== tid[k]) begin
        errors++; $display("FAIL directed%0d got ok=%b rsp=%b id=%b %b_%h exp id=%b %h", k, ok, got, rid, c, s, tid[k], exp_v[k]);
      end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL directed%0d_latency got %0d exp 3", k, lat); end
    end
  endtask

  task automatic test_random();
    bit ok, got, id; logic [31:0] a, b, s; logic cin, c, rid; int lat; logic [32:0] e;
    for (int k = 0; k < 20; k++) begin
      id = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      if (k == 0) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; end
      e = model_add(a, b, cin);
      do_accept(id, a, b, cin, ok);
      wait_rsp(got, s, c, rid, lat);
      checks++;
      if (!ok || !got || {c, s} !== e || rid !== id || lat !== 3) begin
        errors++; $display("FAIL random%0d got ok=%b rsp=%b id=%b %b_%h lat=%0d exp id=%b %h lat=3", k, ok, got, rid, c, s, lat, id, e);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [33:0] expq[$]; int accq[$];
    logic [33:0] e; bit r0, r1, next_grant; int last_acc, n_acc, n_rsp, acc;
    apply_reset();
    rsp_ready = 1'b1; next_grant = 1'b0; last_acc = -100; n_acc = 0; n_rsp = 0;
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1));
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1));
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      r0 = req0_ready; r1 = req1_ready;
      checks++;
      if (r0 && r1) begin errors++; $display("FAIL rr_both_ready cycle %0d got 11 exp at most one", cyc); end
      if (r0 || r1) begin
        checks++;
        if (r1 !== next_grant) begin errors++; $display("FAIL rr_grant cycle %0d got %b exp %b", cyc, r1, next_grant); end
        if (n_acc > 0) begin
          checks++;
          if (cyc - last_acc != 4) begin errors++; $display("FAIL rr_interval got %0d exp 4", cyc - last_acc); end
        end
        e = r1 ? {1'b1, model_add(req1_a, req1_b, req1_cin)} : {1'b0, model_add(req0_a, req0_b, req0_cin)};
        expq.push_back(e); accq.push_back(cyc);
        last_acc = cyc; n_acc++; next_grant = !next_grant;
      end
      if (rsp_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rr_spurious_rsp cycle %0d got valid exp none", cyc);
        end else begin
          e = expq.pop_front(); acc = accq.pop_front(); n_rsp++;
          if ({rsp_id, rsp_cout, rsp_sum} !== e || cyc - acc != 3) begin
            errors++; $display("FAIL rr_rsp got id=%b %b_%h lat=%0d exp %h lat=3", rsp_id, rsp_cout, rsp_sum, cyc - acc, e);
          end
        end
      end
      @(posedge clk); #1;
      if (r0) begin req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1)); end
      if (r1) begin req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1)); end
    end
    checks++;
    if (n_rsp < 8) begin errors++; $display("FAIL rr_count got %0d responses exp >= 8", n_rsp); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [32:0] e; logic [31:0] hs; logic hc, hid; bit got;
    apply_reset();
    rsp_ready = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'b1;
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'b0;
    e = model_add(req0_a, req0_b, req0_cin);
    req0_valid = 1'b1; req1_valid = 1'b1;
    got = 1'b0; hs = '0; hc = 1'b0; hid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; hs = rsp_sum; hc = rsp_cout; hid = rsp_id; end
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!got || {hc, hs} !== e || hid !== 1'b0) begin
      errors++; $display("FAIL stall_first got rsp=%b id=%b %b_%h exp id=0 %h", got, hid, hc, hs, e);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== hs || rsp_cout !== hc || rsp_id !== hid || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got v=%b %b_%h id=%b rdy=%b%b exp v=1 %b_%h id=%b rdy=00",
                           k, rsp_valid, rsp_cout, rsp_sum, rsp_id, req0_ready, req1_ready, hc, hs, hid);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL stall_release got v=%b rdy=%b%b exp v=0 rdy=01", rsp_valid, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok, got, r0, r1; logic [31:0] s; logic c, rid; int lat; logic [32:0] e; bit seen;
    apply_reset();
    rsp_ready = 1'b1;
    do_accept(1'b1, 32'h1234FFFF, 32'h0000_0001, 1'b1, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || rsp_valid !== 1'b0 || rsp_sum !== 32'h0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got ok=%b v=%b %b_%h id=%b exp v=0 0_00000000 id=0", ok, rsp_valid, rsp_cout, rsp_sum, rsp_id);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_dropped got rsp_valid=1 exp 0"); end
    @(posedge clk); #1;
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1));
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1));
    e = model_add(req0_a, req0_b, req0_cin);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    r0 = req0_ready; r1 = req1_ready;
    checks++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL midreset_prio got rdy=%b%b exp 10", r0, r1); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_a = ~req0_a;
    wait_rsp(got, s, c, rid, lat);
    checks++;
    if (!got || {c, s} !== e || rid !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL midreset_next got rsp=%b id=%b %b_%h lat=%0d exp id=0 %h lat=3", got, rid, c, s, lat, e);
    end
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_round_robin();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
